// File: rtl/mem_axi_master_bridge_pkg.sv
// Shared state encoding, AXI protection constants and helpers for the
// native-bus to AXI4-Lite master bridge.
package mem_axi_master_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WR_AW = 3'd1,
      ST_WR_B  = 3'd2,
      ST_RD_AR = 3'd3,
      ST_RD_R  = 3'd4,
      ST_RESP  = 3'd5
   } state_e;

   localparam logic [2:0] PROT_DATA = 3'b000;
   localparam logic [2:0] PROT_INSN = 3'b100;

   // States in which the bridge is waiting on the AXI slave.
   function automatic logic is_busy(input state_e s);
      return (s == ST_WR_AW) || (s == ST_WR_B) || (s == ST_RD_AR) || (s == ST_RD_R);
   endfunction

   function automatic logic is_read(input state_e s);
      return (s == ST_RD_AR) || (s == ST_RD_R);
   endfunction

endpackage

// File: rtl/mem_axi_master_bridge_if.sv
// AXI4-Lite channel bundle between the bridge (master) and the downstream slave.
interface mem_axi_master_bridge_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              awvalid;
   logic              awready;
   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              wvalid;
   logic              wready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              bvalid;
   logic              bready;
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              rvalid;
   logic              rready;
   logic [31:0]       rdata;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, arready, rvalid, rdata
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, arready, rvalid, rdata
   );
endinterface

// File: rtl/mem_axi_master_bridge_bus_watchdog.sv
// Saturating transaction watchdog: cleared by load, counts while enabled,
// flags expiry when the count reaches TIMEOUT_CYC-1.
module mem_axi_master_bridge_bus_watchdog #(
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic resetn,
   input  logic load,
   input  logic en,
   output logic expire
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (en && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/mem_axi_master_bridge.sv
// Converts the core's mem_valid/mem_ready bus into single-outstanding AXI4-Lite
// transactions, with a watchdog that aborts a transaction the slave never finishes.
module mem_axi_master_bridge
   import mem_axi_master_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           mem_valid,
   input  logic                           mem_instr,
   input  logic [ADDR_W-1:0]              mem_addr,
   input  logic [31:0]                    mem_wdata,
   input  logic [3:0]                     mem_wstrb,
   output logic                           mem_ready,
   output logic [31:0]                    mem_rdata,
   mem_axi_master_bridge_if.master        m_axi,
   output logic                           timeout_err
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic              instr_q, instr_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              arvalid_q, arvalid_d;
   logic              bready_q, bready_d;
   logic              rready_q, rready_d;
   logic              mem_ready_q, mem_ready_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   logic              timeout_err_q, timeout_err_d;

   logic wd_load, wd_en, wd_expire;
   logic aw_fin, w_fin, b_hs, r_hs;

   assign wd_load = (state_q == ST_IDLE) && mem_valid;
   assign wd_en   = is_busy(state_q);

   mem_axi_master_bridge_bus_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_bus_watchdog (
      .clk    (clk),
      .resetn (resetn),
      .load   (wd_load),
      .en     (wd_en),
      .expire (wd_expire)
   );

   // A channel counts as finished once its valid is low or it handshakes this cycle.
   assign aw_fin = !awvalid_q || m_axi.awready;
   assign w_fin  = !wvalid_q  || m_axi.wready;
   assign b_hs   = m_axi.bvalid && bready_q;
   assign r_hs   = m_axi.rvalid && rready_q;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      instr_d       = instr_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      arvalid_d     = arvalid_q;
      bready_d      = 1'b1;
      rready_d      = 1'b1;
      mem_rdata_d   = mem_rdata_q;
      timeout_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem_valid) begin
               addr_d  = mem_addr;
               wdata_d = mem_wdata;
               wstrb_d = mem_wstrb;
               instr_d = mem_instr;
               if (|mem_wstrb) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = ST_WR_AW;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = ST_RD_AR;
               end
            end
         end
         ST_WR_AW: begin
            if (m_axi.awready) awvalid_d = 1'b0;
            if (m_axi.wready)  wvalid_d  = 1'b0;
            if (aw_fin && w_fin) begin
               state_d = b_hs ? ST_RESP : ST_WR_B;
            end
         end
         ST_WR_B: begin
            if (b_hs) state_d = ST_RESP;
         end
         ST_RD_AR: begin
            if (m_axi.arready) begin
               arvalid_d = 1'b0;
               if (r_hs) begin
                  mem_rdata_d = m_axi.rdata;
                  state_d     = ST_RESP;
               end else begin
                  state_d = ST_RD_R;
               end
            end
         end
         ST_RD_R: begin
            if (r_hs) begin
               mem_rdata_d = m_axi.rdata;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A genuine completion in the expiry cycle wins over the abort.
      if (wd_expire && (state_d != ST_RESP)) begin
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         arvalid_d     = 1'b0;
         timeout_err_d = 1'b1;
         state_d       = ST_RESP;
         if (is_read(state_q)) mem_rdata_d = ERR_DATA;
      end

      mem_ready_d = (state_d == ST_RESP);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         instr_q       <= 1'b0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         bready_q      <= 1'b1;
         rready_q      <= 1'b1;
         mem_ready_q   <= 1'b0;
         mem_rdata_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         instr_q       <= instr_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         arvalid_q     <= arvalid_d;
         bready_q      <= bready_d;
         rready_q      <= rready_d;
         mem_ready_q   <= mem_ready_d;
         mem_rdata_q   <= mem_rdata_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign mem_ready     = mem_ready_q;
   assign mem_rdata     = mem_rdata_q;
   assign timeout_err   = timeout_err_q;

   assign m_axi.awvalid = awvalid_q;
   assign m_axi.awaddr  = addr_q;
   assign m_axi.awprot  = PROT_DATA;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = wstrb_q;
   assign m_axi.bready  = bready_q;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.araddr  = addr_q;
   assign m_axi.arprot  = instr_q ? PROT_INSN : PROT_DATA;
   assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_mem_axi_master_bridge.sv
// Bench for mem_axi_master_bridge: table of directed transactions, back-to-back,
// randomized transactions against a latency/result model, and reset mid-transaction.
module tb_mem_axi_master_bridge;

   localparam int          TMO = 16;
   localparam logic [31:0] ERR = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_valid, mem_instr;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        timeout_err;

   int n_err = 0;
   int n_chk = 0;

   mem_axi_master_bridge_if #(.ADDR_W(32)) bus ();

   mem_axi_master_bridge #(
      .ADDR_W      (32),
      .TIMEOUT_CYC (TMO),
      .ERR_DATA    (ERR)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .mem_valid   (mem_valid),
      .mem_instr   (mem_instr),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .m_axi       (bus),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // Slave timing is given as edge offsets from edge N (the edge sampling mem_valid):
   // awready at N+1+da, wready at N+1+dw, bvalid db edges after the later of the two;
   // arready at N+1+dar, rvalid dr edges after arready.
   typedef struct {
      bit          wr;
      bit          instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          da, dw, db, dar, dr;
      logic [31:0] rdata;
      int          exp_k;
      bit          exp_to;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t tbl[8];

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic vec_t mk(input bit wr, input bit instr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input int da, input int dw, input int db, input int dar, input int dr,
                               input logic [31:0] rdata, input int ek, input bit eto,
                               input logic [31:0] erd);
      vec_t v;
      v.wr = wr; v.instr = instr; v.addr = addr; v.wdata = wdata; v.strb = strb;
      v.da = da; v.dw = dw; v.db = db; v.dar = dar; v.dr = dr; v.rdata = rdata;
      v.exp_k = ek; v.exp_to = eto; v.exp_rdata = erd;
      return v;
   endfunction

   // Edge offset at which the slave would finish the transaction.
   function automatic int done_at(input vec_t v);
      return v.wr ? (1 + max2(v.da, v.dw) + v.db) : (1 + v.dar + v.dr);
   endfunction

   // Reference: the transaction ends at the slave's completion edge unless the
   // watchdog's TMO-edge budget runs out first, in which case reads return ERR.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      int   d;
      r = v;
      d = done_at(v);
      r.exp_to    = (d > TMO);
      r.exp_k     = r.exp_to ? TMO : d;
      r.exp_rdata = r.exp_to ? ERR : v.rdata;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ctrl"}, {25'd0, bus.awvalid, bus.wvalid, bus.arvalid, mem_ready,
                             timeout_err, bus.bready, bus.rready}, 32'h3);
      check({tag, "_rdata"}, mem_rdata, 32'h0);
      check({tag, "_addr"}, bus.awaddr | bus.araddr, 32'h0);
      check({tag, "_wdata"}, {bus.wdata[31:4], bus.wdata[3:0] | bus.wstrb}, 32'h0);
   endtask

   task automatic zero_slave();
      bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
   endtask

   // Call at a negedge. skip = edges to wait (mem_valid held) before edge N.
   // keep = return as soon as mem_ready is seen, leaving mem_valid asserted.
   task automatic run_txn(input vec_t v, input int skip, input bit keep, input string tag);
      int k, e, limit, rdy_k, rdy_n, to_n, aw_n, w_n, ar_n, shape_err, field_err;
      bit to_at;
      logic [31:0] rd_at;
      bit exp_aw, exp_w, exp_ar;
      rdy_k = -1; rdy_n = 0; to_n = 0; aw_n = 0; w_n = 0; ar_n = 0;
      shape_err = 0; field_err = 0; to_at = 1'b0; rd_at = 32'h0;
      mem_valid = 1'b1;
      mem_instr = v.instr;
      mem_addr  = v.addr;
      mem_wdata = v.wdata;
      mem_wstrb = v.wr ? v.strb : 4'h0;
      for (int s = 0; s < skip; s++) begin
         @(posedge clk); @(negedge clk);
         if (bus.awvalid || bus.wvalid || bus.arvalid || mem_ready) shape_err++;
      end
      limit = max2(max2(done_at(v), v.exp_k), v.wr ? 1 + max2(v.da, v.dw) : 1 + v.dar) + 3;
      k = -1;
      while (1) begin
         if (k >= 0) begin
            exp_aw = v.wr  && (k < ((1 + v.da  < v.exp_k) ? 1 + v.da  : v.exp_k));
            exp_w  = v.wr  && (k < ((1 + v.dw  < v.exp_k) ? 1 + v.dw  : v.exp_k));
            exp_ar = !v.wr && (k < ((1 + v.dar < v.exp_k) ? 1 + v.dar : v.exp_k));
            if (bus.awvalid !== exp_aw || bus.wvalid !== exp_w || bus.arvalid !== exp_ar)
               shape_err++;
            if (bus.awvalid && (bus.awaddr !== v.addr || bus.awprot !== 3'b000)) field_err++;
            if (bus.wvalid && (bus.wdata !== v.wdata || bus.wstrb !== v.strb)) field_err++;
            if (bus.arvalid && (bus.araddr !== v.addr ||
                                bus.arprot !== (v.instr ? 3'b100 : 3'b000))) field_err++;
            if (bus.bready !== 1'b1 || bus.rready !== 1'b1) field_err++;
            if (timeout_err === 1'b1) to_n++;
            if (mem_ready === 1'b1) begin
               rdy_n++;
               if (rdy_k < 0) begin
                  rdy_k = k;
                  rd_at = mem_rdata;
                  to_at = timeout_err;
               end
               if (!keep) mem_valid = 1'b0;
            end
         end
         e = k + 1;
         bus.awready = v.wr  && (e == 1 + v.da);
         bus.wready  = v.wr  && (e == 1 + v.dw);
         bus.bvalid  = v.wr  && (e == done_at(v));
         bus.arready = !v.wr && (e == 1 + v.dar);
         bus.rvalid  = !v.wr && (e == done_at(v));
         bus.rdata   = (!v.wr && e == done_at(v)) ? v.rdata : 32'h0;
         if (bus.awvalid && bus.awready) aw_n++;
         if (bus.wvalid  && bus.wready)  w_n++;
         if (bus.arvalid && bus.arready) ar_n++;
         if ((keep && rdy_k >= 0) || k >= limit) break;
         @(posedge clk); @(negedge clk);
         k++;
      end
      check({tag, "_ready_count"}, rdy_n, 1);
      check({tag, "_ready_cycle"}, rdy_k, v.exp_k);
      check({tag, "_timeout_count"}, to_n, {31'd0, v.exp_to});
      check({tag, "_timeout_with_ready"}, {31'd0, to_at}, {31'd0, v.exp_to});
      if (!v.wr) check({tag, "_rdata"}, rd_at, v.exp_rdata);
      check({tag, "_aw_hs"}, aw_n, (v.wr && (1 + v.da <= v.exp_k)) ? 1 : 0);
      check({tag, "_w_hs"}, w_n, (v.wr && (1 + v.dw <= v.exp_k)) ? 1 : 0);
      check({tag, "_ar_hs"}, ar_n, (!v.wr && (1 + v.dar <= v.exp_k)) ? 1 : 0);
      check({tag, "_valid_shape"}, shape_err, 0);
      check({tag, "_axi_fields"}, field_err, 0);
   endtask

   initial begin
      vec_t v, v2;
      int   bad;
      resetn    = 1'b0;
      mem_valid = 1'b0; mem_instr = 1'b0;
      mem_addr  = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
      zero_slave();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      resetn = 1'b1;

      //           wr instr addr        wdata         strb  da dw db dar dr rdata         k  to rdata
      tbl[0] = mk(1, 0, 32'h100, 32'h11223344, 4'hF, 0, 0, 1, 0, 0, 32'h0,        2, 0, 32'h0);
      tbl[1] = mk(1, 0, 32'h104, 32'hA5A5A5A5, 4'hF, 0, 3, 1, 0, 0, 32'h0,        5, 0, 32'h0);
      tbl[2] = mk(0, 1, 32'h204, 32'h0,        4'h0, 0, 0, 0, 0, 5, 32'hCAFEF00D, 6, 0, 32'hCAFEF00D);
      tbl[3] = mk(0, 0, 32'h300, 32'h0,        4'h0, 0, 0, 0, 0, 25, 32'h12345678, 16, 1, 32'hDEADBEEF);
      tbl[4] = mk(1, 0, 32'h108, 32'h0000BB00, 4'h2, 2, 1, 0, 0, 0, 32'h0,        3, 0, 32'h0);
      tbl[5] = mk(0, 0, 32'h20C, 32'h0,        4'h0, 0, 0, 0, 2, 0, 32'h0BADF00D, 3, 0, 32'h0BADF00D);
      tbl[6] = mk(1, 0, 32'h10C, 32'h55AA55AA, 4'hF, 20, 0, 0, 0, 0, 32'h0,       16, 1, 32'h0);
      tbl[7] = mk(0, 1, 32'h400, 32'h0,        4'h0, 0, 0, 0, 14, 0, 32'h87654321, 15, 0, 32'h87654321);
      for (int i = 0; i < 8; i++) begin
         run_txn(tbl[i], 0, 1'b0, $sformatf("vec%0d", i));
      end

      // Back-to-back: mem_valid stays high with the next request right after mem_ready.
      v  = mk(1, 0, 32'h500, 32'hFEEDFACE, 4'hF, 0, 0, 1, 0, 0, 32'h0, 2, 0, 32'h0);
      v2 = mk(0, 0, 32'h504, 32'h0, 4'h0, 0, 0, 0, 1, 1, 32'h13579BDF, 3, 0, 32'h13579BDF);
      run_txn(v, 0, 1'b1, "b2b_wr");
      run_txn(v2, 1, 1'b0, "b2b_rd");

      for (int i = 0; i < 40; i++) begin
         v.wr    = $urandom_range(0, 1);
         v.instr = !v.wr && ($urandom_range(0, 1) == 1);
         v.addr  = $urandom & 32'hFFFF_FFFC;
         v.wdata = $urandom;
         v.strb  = v.wr ? 4'($urandom_range(1, 15)) : 4'h0;
         v.da    = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
         v.dw    = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
         v.db    = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
         v.dar   = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
         v.dr    = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
         v.rdata = $urandom;
         if (done_at(v) == TMO) begin
            v.db = v.db + 1;
            v.dr = v.dr + 1;
         end
         v = model(v);
         run_txn(v, 0, 1'b0, $sformatf("rnd%0d", i));
      end

      // Reset pulsed while waiting for the write response.
      mem_valid = 1'b1; mem_instr = 1'b0;
      mem_addr  = 32'h600; mem_wdata = 32'h0F0F0F0F; mem_wstrb = 4'hF;
      @(posedge clk); @(negedge clk);
      bus.awready = 1'b1; bus.wready = 1'b1;
      @(posedge clk); @(negedge clk);
      zero_slave();
      check("wr_b_entered", {29'd0, bus.awvalid, bus.wvalid, mem_ready}, 32'h0);
      resetn    = 1'b0;
      mem_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      check_idle("reset_mid_txn");
      resetn      = 1'b1;
      bus.bvalid  = 1'b1;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); @(negedge clk);
         bus.bvalid = 1'b0;
         if (mem_ready || timeout_err || bus.awvalid || bus.wvalid || bus.arvalid) bad++;
      end
      check("no_ready_after_reset", bad, 0);
      v = mk(1, 0, 32'h604, 32'h76543210, 4'hC, 1, 0, 1, 0, 0, 32'h0, 3, 0, 32'h0);
      run_txn(v, 0, 1'b0, "post_reset_wr");
      v = mk(0, 0, 32'h608, 32'h0, 4'h0, 0, 0, 0, 0, 1, 32'h2468ACE0, 2, 0, 32'h2468ACE0);
      run_txn(v, 0, 1'b0, "post_reset_rd");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "bench timed out");
   end

endmodule
